memory_request_issuer: RTL and testbench
========================================

# memory_request_issuer

Front-end stage directly upstream of `memory_system`. It accepts one CPU memory request at a time, up to 4 words long, and splits any request that crosses a 16-byte line into a primary and a secondary cache access. It loads those accesses into the two-slot tick-tock interface (`tt_*`, `tick_tock_phase0`) and reassembles results from `cd_access_out_full_data` into one in-order response per request.

## Interface
- No parameters; all widths are fixed by the `memory_system` interface.
- `main_clk` in 1: sole clock, rising edge.
- `main_reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1, `req_ready` out 1: request handshake; transfer when both are 1.
- `req_address` in 31: byte address.
- `req_length` in 3: word count, 1..4. 0 is treated as 1; 5..7 are clipped to 4.
- `req_is_byte_op` in 1: byte access; forces length 1.
- `req_is_write_op` in 1: write.
- `req_wdata` in 4x16: write words; index 0 is the first word.
- `rsp_valid` out 1: single-cycle pulse; no backpressure.
- `rsp_data` out 4x16: read words; index 0 is the first word. Zero for writes.
- `tick_tock_phase0` out 2: producer pointer.
- `tick_tock_phase1`, `tick_tock_phase2` in 2 each; `tick_tock_phase2_moved` in 1.
- `tt_address` out 2x31; `tt_data_in0`, `tt_data_in1` out 4x16 each.
- `tt_move` out 2x2; `tt_secondary` out 2x1; `tt_access_length` out 2x3.
- `tt_is_byte_op` out 2x1; `tt_is_write_op` out 2x1.
- `cd_access_out_full_data` in 8x16: line-wide result from the cache.

## Operation
- **Slot and credit rules**
  - Slot index is `tick_tock_phase0[0]`.
  - An entry may be written only when `(phase0 - phase2) mod 4 < 2`. A slot is therefore never overwritten before its result has retired.
- **Split computation**
  - Word offset `o = req_address[3:1]`.
  - Primary word count `p = min(L, 8-o)`. Secondary word count `s = L - p`.
- **Primary entry**
  - `tt_address = req_address`, `tt_secondary = 0`, `tt_move = 3`.
  - `tt_access_length = p-1`.
  - Data slot gets `req_wdata`.
- **Secondary entry** (only when `s > 0`)
  - `tt_address = req_address` (the memory system forms the next-line address), `tt_secondary = 1`.
  - `tt_move = p-1`, `tt_access_length = s-1`.
  - Data slot gets `req_wdata` unshifted; the memory system applies `tt_move`.
- **FSM**
  - **IDLE**: `req_ready = 1` when 1 credit is free and the request will not split, or when 2 credits are free. Split requests with only 1 free credit are also accepted. On accept, write the primary entry. If `s > 0` and a second credit is free, write the secondary entry in the same cycle (`phase0 += 2`); otherwise go to **SEC**.
  - **SEC**: `req_ready = 0`. Hold the latched request and write the secondary entry when a credit frees. Return to IDLE.
- **Metadata FIFO** (2 entries, indexed by slot bit)
  - Per-entry fields: `is_write`, `is_secondary`, `split`, `o`, `p`, `s`.
- **Retire**: on `tick_tock_phase2_moved = 1`, the completing slot is `(phase2-1)[0]`.
  - Read primary: capture words `o..o+p-1` into assembly words `0..p-1`.
  - Read secondary: capture words `0..s-1` into assembly words `p..p+s-1`.
  - Unused assembly words are 0.
  - A response is produced when the non-split primary retires, or when the secondary retires.
- **Ordering**: responses are strictly in request order.
- **Byte reads**: return the full addressed word in `rsp_data[0]`.

## Timing
- **Reset values**
  - Outputs: `tick_tock_phase0 = 0`, `req_ready = 0` during reset, `rsp_valid = 0`, `rsp_data = 0`.
  - All `tt_*` outputs are 0. FSM is IDLE. Metadata FIFO and assembly register are cleared.
- `main_reset` must be asserted together with the memory system's reset. Outstanding accesses are discarded and no responses are emitted for them.
- **Issue timing**
  - A request accepted at edge t has `tt_*` and the incremented `phase0` visible after t.
  - The memory system can consume an entry at the earliest at edge t+1.
- **Response timing**: `rsp_valid` pulses in the cycle after the retiring `tick_tock_phase2_moved` cycle. Minimum request-to-response latency is 3 cycles from accept when there is no hard fault.
- **Hard-fault stall**
  - While `phase1`/`phase2` are frozen, credits do not free and `req_ready` falls once 2 entries are outstanding.
  - No entry is modified while it is outstanding.
- **Simultaneous events**: a retire and an accept in the same cycle are allowed. The freed credit is visible one cycle later; credits are registered.
- **Wrap-around**: all phase arithmetic is mod 4.

## Test plan
- **Aligned read**: read `0x100`, length 4. Expect a single entry with `move = 3`, `access_length = 3`; `rsp_data` = line words 0..3 one cycle after `phase2_moved`.
- **Split read, both credits free**: read `0x10C` (`o = 6`), length 4. Expect primary `access_length = 1`, `move = 3`, and secondary `access_length = 1`, `move = 1`, both issued in the same cycle. `rsp_data` = {primary w6, primary w7, secondary w0, secondary w1}.
- **Split with one credit**: issue the same split while one access is outstanding. Expect the FSM to enter SEC, `req_ready = 0` until the secondary is written, and exactly 2 responses, in order.
- **Hard-fault stall**: freeze `phase1`/`phase2` for 20 cycles with 2 entries outstanding. Expect `req_ready = 0`, `tt_*` stable, no `rsp_valid`; normal resume afterwards.
- **Byte write then read**: byte write `0x201`, then read `0x200` length 1. Expect the write response with `rsp_data = 0`, then the read response, in order.
- **Reset mid-split**: assert `main_reset` while in SEC. Expect all outputs at reset values immediately, and no responses afterwards.

Source files
------------

// File: rtl/memory_request_issuer.sv
// Request front-end for memory_system: splits line-crossing CPU requests into
// primary/secondary tick-tock entries and reassembles one in-order response each.
module memory_request_issuer (
  input  logic                 main_clk,
  input  logic                 main_reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [30:0]          req_address,
  input  logic [2:0]           req_length,
  input  logic                 req_is_byte_op,
  input  logic                 req_is_write_op,
  input  logic [3:0][15:0]     req_wdata,
  output logic                 rsp_valid,
  output logic [3:0][15:0]     rsp_data,
  output logic [1:0]           tick_tock_phase0,
  input  logic [1:0]           tick_tock_phase1,
  input  logic [1:0]           tick_tock_phase2,
  input  logic                 tick_tock_phase2_moved,
  output logic [1:0][30:0]     tt_address,
  output logic [3:0][15:0]     tt_data_in0,
  output logic [3:0][15:0]     tt_data_in1,
  output logic [1:0][1:0]      tt_move,
  output logic [1:0]           tt_secondary,
  output logic [1:0][2:0]      tt_access_length,
  output logic [1:0]           tt_is_byte_op,
  output logic [1:0]           tt_is_write_op,
  input  logic [7:0][15:0]     cd_access_out_full_data
);

  typedef enum logic {S_IDLE, S_SEC} state_e;

  // One tick-tock slot: the fields driven to memory_system plus retire metadata.
  typedef struct packed {
    logic [30:0]      addr;
    logic [3:0][15:0] wdata;
    logic [1:0]       move;
    logic             sec;
    logic [2:0]       alen;
    logic             byte_op;
    logic             write;
    logic             split;
    logic [2:0]       o;
    logic [2:0]       p;
    logic [2:0]       s;
  } entry_t;

  function automatic entry_t build_entry(input logic [30:0] addr, input logic [3:0][15:0] wdata,
                                         input logic write, input logic byte_op, input logic sec,
                                         input logic [2:0] p, input logic [2:0] s);
    entry_t e;
    e         = '0;
    e.addr    = addr;
    e.wdata   = wdata;
    e.write   = write;
    e.byte_op = byte_op;
    e.sec     = sec;
    e.split   = (s != 3'd0);
    e.o       = addr[3:1];
    e.p       = p;
    e.s       = s;
    e.move    = sec ? 2'(p - 3'd1) : 2'd3;
    e.alen    = sec ? (s - 3'd1) : (p - 3'd1);
    return e;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       phase0_q, phase0_d, phase2_q;
  entry_t           ent_q [2];
  entry_t           lat_q;
  logic [3:0][15:0] asm_q, asm_d;
  logic             rsp_valid_q;
  logic [3:0][15:0] rsp_data_q;

  logic [2:0] req_len, req_p, req_s;
  logic [3:0] room;
  entry_t     prim_ent, sec_ent, ent_a, ent_b, ret;
  logic       we_a, we_b, latch_en, slot_a, ret_slot;
  logic [1:0] outstanding;
  logic       one_free, two_free, accept;
  logic       unused_phase1;

  // phase1 is the memory system's consume pointer; credits only depend on retirement.
  assign unused_phase1 = ^tick_tock_phase1;

  assign outstanding = phase0_q - phase2_q;
  assign one_free    = (outstanding < 2'd2);
  assign two_free    = (outstanding == 2'd0);
  assign slot_a      = phase0_q[0];
  assign req_ready   = ~main_reset & (state_q == S_IDLE) & one_free;
  assign accept      = req_valid & req_ready;

  always_comb begin
    if (req_is_byte_op || req_length == 3'd0) req_len = 3'd1;
    else if (req_length > 3'd4)                req_len = 3'd4;
    else                                       req_len = req_length;
    room     = 4'd8 - {1'b0, req_address[3:1]};
    req_p    = ({1'b0, req_len} < room) ? req_len : room[2:0];
    req_s    = req_len - req_p;
    prim_ent = build_entry(req_address, req_wdata, req_is_write_op, req_is_byte_op, 1'b0, req_p, req_s);
    sec_ent  = build_entry(req_address, req_wdata, req_is_write_op, 1'b0, 1'b1, req_p, req_s);
  end

  always_comb begin
    state_d  = state_q;
    phase0_d = phase0_q;
    we_a     = 1'b0;
    we_b     = 1'b0;
    latch_en = 1'b0;
    ent_a    = prim_ent;
    ent_b    = sec_ent;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_a = 1'b1;
          if (req_s == 3'd0) begin
            phase0_d = phase0_q + 2'd1;
          end else if (two_free) begin
            we_b     = 1'b1;
            phase0_d = phase0_q + 2'd2;
          end else begin
            phase0_d = phase0_q + 2'd1;
            latch_en = 1'b1;
            state_d  = S_SEC;
          end
        end
      end
      S_SEC: begin
        ent_a = lat_q;
        if (one_free) begin
          we_a     = 1'b1;
          phase0_d = phase0_q + 2'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The slot that just completed is the one behind the advanced phase2.
  assign ret_slot = ~tick_tock_phase2[0];
  assign ret      = ent_q[ret_slot];

  always_comb begin
    asm_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (ret.sec) asm_d[i] = asm_q[i];
      if (!ret.sec && (3'(i) < ret.p))
        asm_d[i] = cd_access_out_full_data[ret.o + 3'(i)];
      else if (ret.sec && (3'(i) >= ret.p) && (3'(i) < ret.p + ret.s))
        asm_d[i] = cd_access_out_full_data[3'(i) - ret.p];
    end
  end

  always_ff @(posedge main_clk or posedge main_reset) begin
    if (main_reset) begin
      state_q     <= S_IDLE;
      phase0_q    <= 2'd0;
      phase2_q    <= 2'd0;
      lat_q       <= '0;
      asm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase0_q    <= phase0_d;
      phase2_q    <= tick_tock_phase2;
      rsp_valid_q <= 1'b0;
      if (latch_en) lat_q <= sec_ent;
      if (tick_tock_phase2_moved) begin
        asm_q <= asm_d;
        if (!ret.split || ret.sec) begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= ret.write ? '0 : asm_d;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge main_clk or posedge main_reset) begin
      if (main_reset)                          ent_q[gi] <= '0;
      else if (we_a && (slot_a == 1'(gi)))     ent_q[gi] <= ent_a;
      else if (we_b && (slot_a != 1'(gi)))     ent_q[gi] <= ent_b;
    end
    assign tt_address[gi]       = ent_q[gi].addr;
    assign tt_move[gi]          = ent_q[gi].move;
    assign tt_secondary[gi]     = ent_q[gi].sec;
    assign tt_access_length[gi] = ent_q[gi].alen;
    assign tt_is_byte_op[gi]    = ent_q[gi].byte_op;
    assign tt_is_write_op[gi]   = ent_q[gi].write;
  end

  assign tt_data_in0      = ent_q[0].wdata;
  assign tt_data_in1      = ent_q[1].wdata;
  assign tick_tock_phase0 = phase0_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;

endmodule

// File: tb/tb_memory_request_issuer.sv
// Bench for memory_request_issuer: a randomized tick-tock memory environment plus a
// request-level reference model (flat word memory, in-order expected responses).
module tb_memory_request_issuer;

  logic                main_clk = 1'b0;
  logic                main_reset = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [30:0]         req_address = '0;
  logic [2:0]          req_length = '0;
  logic                req_is_byte_op = 1'b0;
  logic                req_is_write_op = 1'b0;
  logic [3:0][15:0]    req_wdata = '0;
  logic                rsp_valid;
  logic [3:0][15:0]    rsp_data;
  logic [1:0]          tick_tock_phase0;
  logic [1:0]          ph1 = 2'd0;
  logic [1:0]          ph2 = 2'd0;
  logic                moved = 1'b0;
  logic [1:0][30:0]    tt_address;
  logic [3:0][15:0]    tt_data_in0, tt_data_in1;
  logic [1:0][1:0]     tt_move;
  logic [1:0]          tt_secondary;
  logic [1:0][2:0]     tt_access_length;
  logic [1:0]          tt_is_byte_op, tt_is_write_op;
  logic [7:0][15:0]    cd_data = '0;

  memory_request_issuer dut (
    .main_clk(main_clk), .main_reset(main_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_length(req_length), .req_is_byte_op(req_is_byte_op), .req_is_write_op(req_is_write_op),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tick_tock_phase0(tick_tock_phase0), .tick_tock_phase1(ph1), .tick_tock_phase2(ph2),
    .tick_tock_phase2_moved(moved), .tt_address(tt_address), .tt_data_in0(tt_data_in0),
    .tt_data_in1(tt_data_in1), .tt_move(tt_move), .tt_secondary(tt_secondary),
    .tt_access_length(tt_access_length), .tt_is_byte_op(tt_is_byte_op),
    .tt_is_write_op(tt_is_write_op), .cd_access_out_full_data(cd_data)
  );

  always #5 main_clk = ~main_clk;

  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  logic [63:0] exp_q [$];
  logic [15:0] env_mem [int];
  logic [15:0] ref_mem [int];
  logic [7:0][15:0] res [2];
  bit   freeze = 1'b1;
  int   env_rate = 100;
  logic [1:0] p0_exp = 2'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mem_init(input int wa);
    logic [31:0] h;
    h = (wa * 32'h9E37) ^ 32'h5A5A;
    return h[15:0];
  endfunction

  function automatic logic [15:0] env_rd(input int wa);
    if (env_mem.exists(wa)) return env_mem[wa];
    return mem_init(wa);
  endfunction

  function automatic logic [15:0] ref_rd(input int wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return mem_init(wa);
  endfunction

  // Memory-system stand-in: executes an entry when consumed, returns its line on retire.
  task automatic env_exec(input bit s);
    logic [30:0]      a;
    logic [3:0][15:0] d;
    logic [15:0]      w;
    int base, o, n, di;
    a    = tt_address[s];
    d    = s ? tt_data_in1 : tt_data_in0;
    base = (int'(a[30:4]) + (tt_secondary[s] ? 1 : 0)) * 8;
    o    = int'(a[3:1]);
    n    = int'(tt_access_length[s]) + 1;
    if (tt_is_write_op[s]) begin
      if (tt_is_byte_op[s]) begin
        w = env_rd(base + o);
        if (a[0]) w[15:8] = d[0][7:0];
        else      w[7:0]  = d[0][7:0];
        env_mem[base + o] = w;
      end else if (!tt_secondary[s]) begin
        for (int i = 0; i < n; i++)
          if (o + i < 8 && i < 4) env_mem[base + o + i] = d[i];
      end else begin
        for (int i = 0; i < n; i++) begin
          di = int'(tt_move[s]) + 1 + i;
          if (di < 4) env_mem[base + i] = d[di];
        end
      end
    end
    for (int k = 0; k < 8; k++) res[s][k] = env_rd(base + k);
  endtask

  always @(negedge main_clk) begin
    if (main_reset) begin
      ph1 = 2'd0; ph2 = 2'd0; moved = 1'b0;
    end else begin
      moved = 1'b0;
      if (!freeze && ph2 != ph1 && $urandom_range(0, 99) < env_rate) begin
        cd_data = res[ph2[0]];
        ph2     = ph2 + 2'd1;
        moved   = 1'b1;
      end
      if (!freeze && ph1 != tick_tock_phase0 && $urandom_range(0, 99) < env_rate) begin
        env_exec(ph1[0]);
        ph1 = ph1 + 2'd1;
      end
    end
  end

  always @(negedge main_clk) begin
    if (!main_reset && rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else                   chk("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  // Presents one request from a negedge; on acceptance applies it to the reference model.
  task automatic send(input logic [30:0] a, input logic [2:0] len, input bit b, input bit w,
                      input logic [3:0][15:0] wd);
    int L, o, p, wa, t;
    logic [63:0] e;
    logic [15:0] word;
    req_address = a; req_length = len; req_is_byte_op = b; req_is_write_op = w;
    req_wdata = wd; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 300) begin @(negedge main_clk); t++; end
    if (!req_ready) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    L  = b ? 1 : (len == 0) ? 1 : (len > 4) ? 4 : int'(len);
    o  = int'(a[3:1]);
    p  = (L < 8 - o) ? L : 8 - o;
    wa = int'(a[30:1]);
    e  = '0;
    if (w) begin
      if (b) begin
        word = ref_rd(wa);
        if (a[0]) word[15:8] = wd[0][7:0];
        else      word[7:0]  = wd[0][7:0];
        ref_mem[wa] = word;
      end else begin
        for (int i = 0; i < L; i++) ref_mem[wa + i] = wd[i];
      end
    end else begin
      for (int i = 0; i < L; i++) e[i*16 +: 16] = ref_rd(wa + i);
    end
    exp_q.push_back(e);
    p0_exp = p0_exp + ((p < L) ? 2'd2 : 2'd1);
    @(negedge main_clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || ph2 != tick_tock_phase0) && t < 1000) begin
      @(negedge main_clk); t++;
    end
    if (t >= 1000) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge main_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sa;
    int t, snap;
    #1 main_reset = 1'b1;
    #2;
    chk("rst_phase0", 64'(tick_tock_phase0), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_tt_addr", 64'(tt_address), 64'd0);
    chk("rst_tt_len", {52'd0, tt_move, tt_secondary, tt_access_length, tt_is_byte_op, tt_is_write_op}, 64'd0);
    repeat (3) @(negedge main_clk);
    main_reset = 1'b0;
    @(negedge main_clk);
    chk("idle_ready", 64'(req_ready), 64'd1);

    // aligned read
    sa = p0_exp;
    send(31'h100, 3'd4, 1'b0, 1'b0, '0);
    chk("t1_phase0", 64'(tick_tock_phase0), 64'(p0_exp));
    chk("t1_move", 64'(tt_move[sa[0]]), 64'd3);
    chk("t1_alen", 64'(tt_access_length[sa[0]]), 64'd3);
    chk("t1_sec", 64'(tt_secondary[sa[0]]), 64'd0);
    chk("t1_addr", 64'(tt_address[sa[0]]), 64'h100);
    freeze = 1'b0; drain(); freeze = 1'b1;

    // split read with both credits free
    sa = p0_exp;
    send(31'h10C, 3'd4, 1'b0, 1'b0, '0);
    chk("t2_phase0", 64'(tick_tock_phase0), 64'(p0_exp));
    chk("t2_p_alen", 64'(tt_access_length[sa[0]]), 64'd1);
    chk("t2_p_move", 64'(tt_move[sa[0]]), 64'd3);
    chk("t2_s_alen", 64'(tt_access_length[~sa[0]]), 64'd1);
    chk("t2_s_move", 64'(tt_move[~sa[0]]), 64'd1);
    chk("t2_s_sec", 64'(tt_secondary[~sa[0]]), 64'd1);
    freeze = 1'b0; drain(); freeze = 1'b1;

    // split with one credit: parks in the secondary-pending state
    send(31'h120, 3'd1, 1'b0, 1'b0, '0);
    send(31'h10C, 3'd4, 1'b0, 1'b0, '0);
    chk("t3_ready_sec", 64'(req_ready), 64'd0);
    chk("t3_phase0_part", 64'(tick_tock_phase0), 64'(p0_exp - 2'd1));
    repeat (3) @(negedge main_clk);
    chk("t3_ready_hold", 64'(req_ready), 64'd0);
    freeze = 1'b0;
    t = 0;
    while (tick_tock_phase0 != p0_exp && t < 100) begin @(negedge main_clk); t++; end
    chk("t3_phase0_done", 64'(tick_tock_phase0), 64'(p0_exp));
    drain(); freeze = 1'b1;

    // hard-fault stall with two outstanding
    sa = p0_exp;
    send(31'h140, 3'd1, 1'b0, 1'b0, '0);
    send(31'h150, 3'd2, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      chk("t4_ready", 64'(req_ready), 64'd0);
      chk("t4_addr_a", 64'(tt_address[sa[0]]), 64'h140);
      chk("t4_addr_b", 64'(tt_address[~sa[0]]), 64'h150);
      chk("t4_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge main_clk);
    end
    freeze = 1'b0; drain();

    // byte write then read of the same word
    send(31'h201, 3'd1, 1'b1, 1'b1, {16'h1111, 16'h2222, 16'h3333, 16'hABCD});
    send(31'h200, 3'd1, 1'b0, 1'b0, '0);
    drain();

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (n % 40 == 0) env_rate = $urandom_range(25, 100);
      send(31'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(negedge main_clk);
    end
    env_rate = 100;
    drain();

    // reset while the secondary is pending
    freeze = 1'b1;
    send(31'h300, 3'd1, 1'b0, 1'b0, '0);
    send(31'h30E, 3'd3, 1'b0, 1'b0, '0);
    chk("t6_ready_sec", 64'(req_ready), 64'd0);
    main_reset = 1'b1;
    #1;
    chk("t6_rst_phase0", 64'(tick_tock_phase0), 64'd0);
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    chk("t6_rst_rsp", 64'(rsp_valid), 64'd0);
    chk("t6_rst_tt_addr", 64'(tt_address), 64'd0);
    chk("t6_rst_tt_move", 64'(tt_move), 64'd0);
    exp_q.delete();
    p0_exp = 2'd0;
    repeat (2) @(negedge main_clk);
    main_reset = 1'b0;
    freeze = 1'b0;
    snap = rsp_cnt;
    @(negedge main_clk);
    chk("t6_ready_after", 64'(req_ready), 64'd1);
    repeat (20) @(negedge main_clk);
    chk("t6_no_rsp", 64'(rsp_cnt - snap), 64'd0);
    send(31'h104, 3'd2, 1'b0, 1'b0, '0);
    drain();
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
